cpu_mc: RTL and testbench

CPU_MC -- requirements
Module: cpu_mc

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_regfile.sv | 40 ++++
 rtl/cpu_mc.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_mc.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode/state encodings and instruction field positions
//               for the multi-cycle cpu_mc core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [3:0] {
        OP_MV   = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_CMP  = 4'd3,
        OP_LD   = 4'd4,
        OP_ST   = 4'd5,
        OP_MVHI = 4'd6,
        OP_J    = 4'd8,
        OP_JZ   = 4'd9,
        OP_JN   = 4'd10,
        OP_CALL = 4'd12,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_LDWB   = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam int c_data_w     = 16;
    localparam int c_num_regs   = 8;
    localparam int c_op_lsb     = 0;
    localparam int c_op_w       = 4;
    localparam int c_i_bit      = 4;
    localparam int c_rx_lsb     = 5;
    localparam int c_ry_lsb     = 8;
    localparam int c_reg_w      = 3;
    localparam int c_imm8_lsb   = 8;
    localparam int c_imm11_lsb  = 5;
    localparam logic [2:0] c_link_reg = 3'd7;

endpackage

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module      : cpu_regfile
// Description : 8 x 16-bit general purpose registers, two asynchronous read
//               ports and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [c_reg_w-1:0]  i_ra_addr,
    output logic [c_data_w-1:0] o_ra_data,
    input  logic [c_reg_w-1:0]  i_rb_addr,
    output logic [c_data_w-1:0] o_rb_data,
    input  logic                i_we,
    input  logic [c_reg_w-1:0]  i_waddr,
    input  logic [c_data_w-1:0] i_wdata
);

    logic [c_data_w-1:0] r_regs [c_num_regs];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data = r_regs[i_ra_addr];
    assign o_rb_data = r_regs[i_rb_addr];

endmodule

`default_nettype wire

// File: rtl/cpu_mc.sv
// ============================================================================
// Module      : cpu_mc
// Description : Multi-cycle 16-bit CPU with a stallable single memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mc
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_rd,
    output logic                o_mem_wr,
    output logic [c_data_w-1:0] o_mem_wrdata,
    input  logic [c_data_w-1:0] i_mem_rddata,
    input  logic                i_mem_waitrequest,
    output logic                o_halted
);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_W-1:0]     r_pc;
    logic [c_data_w-1:0]   r_ir;
    logic                  r_n;
    logic                  r_z;

    logic                  w_pc_we;
    logic [ADDR_W-1:0]     w_pc_next;
    logic                  w_ir_we;
    logic                  w_flags_we;
    logic [c_data_w-1:0]   w_flag_res;
    logic                  w_rf_we;
    logic [c_reg_w-1:0]    w_rf_waddr;
    logic [c_data_w-1:0]   w_rf_wdata;

    opcode_t               w_op;
    logic                  w_imm;
    logic [c_reg_w-1:0]    w_rx_idx;
    logic [c_reg_w-1:0]    w_ry_idx;
    logic [7:0]            w_imm8;
    logic signed [11:0]    w_br_off;
    logic [c_data_w-1:0]   w_rx_data;
    logic [c_data_w-1:0]   w_ry_data;
    logic [c_data_w-1:0]   w_b;
    logic [c_data_w-1:0]   w_sum;
    logic [c_data_w-1:0]   w_diff;
    logic [ADDR_W-1:0]     w_pc_plus2;
    logic [ADDR_W-1:0]     w_jump_target;
    logic [ADDR_W-1:0]     w_ry_addr;

    cpu_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_ra_addr (w_rx_idx),
        .o_ra_data (w_rx_data),
        .i_rb_addr (w_ry_idx),
        .o_rb_data (w_ry_data),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata)
    );

    assign w_op     = opcode_t'(r_ir[c_op_lsb +: c_op_w]);
    assign w_imm    = r_ir[c_i_bit];
    assign w_rx_idx = r_ir[c_rx_lsb +: c_reg_w];
    assign w_ry_idx = r_ir[c_ry_lsb +: c_reg_w];
    assign w_imm8   = r_ir[c_imm8_lsb +: 8];
    // Branch offset is in halfwords; append the zero LSB before sign extension.
    assign w_br_off = {r_ir[c_imm11_lsb +: 11], 1'b0};

    assign w_b      = w_imm ? {{8{w_imm8[7]}}, w_imm8} : w_ry_data;
    assign w_sum    = w_rx_data + w_b;
    assign w_diff   = w_rx_data - w_b;

    assign w_pc_plus2    = r_pc + ADDR_W'(2);
    assign w_ry_addr     = ADDR_W'(w_ry_data);
    assign w_jump_target = w_imm ? (r_pc + ADDR_W'(w_br_off)) : w_ry_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
            r_n  <= 1'b0;
            r_z  <= 1'b0;
        end else begin
            if (w_pc_we) begin
                r_pc <= w_pc_next;
            end
            if (w_ir_we) begin
                r_ir <= i_mem_rddata;
            end
            if (w_flags_we) begin
                r_n <= w_flag_res[c_data_w-1];
                r_z <= (w_flag_res == '0);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_we      = 1'b0;
        w_pc_next    = w_pc_plus2;
        w_ir_we      = 1'b0;
        w_flags_we   = 1'b0;
        w_flag_res   = w_diff;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rx_idx;
        w_rf_wdata   = w_b;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = r_pc;
        o_mem_wrdata = '0;
        o_halted     = 1'b0;

        case (r_state)
            ST_RST: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                o_mem_rd = 1'b1;
                if (!i_mem_waitrequest) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_ir_we      = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = ST_FETCH;
                w_pc_we      = 1'b1;
                case (w_op)
                    OP_MV:   w_rf_we = 1'b1;
                    OP_ADD: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_sum;
                        w_flags_we = 1'b1;
                        w_flag_res = w_sum;
                    end
                    OP_SUB: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_diff;
                        w_flags_we = 1'b1;
                    end
                    OP_CMP:  w_flags_we = 1'b1;
                    OP_LD,
                    OP_ST:   w_next_state = ST_MEM;
                    OP_MVHI: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = {w_imm8, w_rx_data[7:0]};
                    end
                    OP_J:    w_pc_next = w_jump_target;
                    OP_JZ:   if (r_z) w_pc_next = w_jump_target;
                    OP_JN:   if (r_n) w_pc_next = w_jump_target;
                    OP_CALL: begin
                        w_pc_next  = w_jump_target;
                        w_rf_we    = 1'b1;
                        w_rf_waddr = c_link_reg;
                        w_rf_wdata = c_data_w'(w_pc_plus2);
                    end
                    OP_HALT: begin
                        w_pc_we      = 1'b0;
                        w_next_state = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o_mem_addr = w_ry_addr;
                if (w_op == OP_ST) begin
                    o_mem_wr     = 1'b1;
                    o_mem_wrdata = w_rx_data;
                end else begin
                    o_mem_rd = 1'b1;
                end
                if (!i_mem_waitrequest) begin
                    w_next_state = (w_op == OP_ST) ? ST_FETCH : ST_LDWB;
                end
            end
            ST_LDWB: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = i_mem_rddata;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                w_next_state = ST_RST;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mc.sv
// ============================================================================
// Module      : tb_cpu_mc
// Description : Directed program bench for cpu_mc with a stallable memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wrdata;
    logic [15:0] mem_rddata = '0;
    logic        mem_wait;
    logic        halted;

    int n_total = 0;
    int n_bad   = 0;

    cpu_mc #(
        .ADDR_W   (16),
        .RESET_PC (16'h0100)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .o_mem_addr        (mem_addr),
        .o_mem_rd          (mem_rd),
        .o_mem_wr          (mem_wr),
        .o_mem_wrdata      (mem_wrdata),
        .i_mem_rddata      (mem_rddata),
        .i_mem_waitrequest (mem_wait),
        .o_halted          (halted)
    );

    always #5 clk = ~clk;

    // Memory: program image plus an overlay holding everything stored by the core.
    logic [15:0] img [0:32767];
    logic [15:0] wmem [int];
    int          wcnt = 0;
    int          wr_stall;
    logic [15:0] stall_addr;
    int          cyc = 0;

    assign mem_wait = mem_wr && (mem_addr == stall_addr) && (wcnt < wr_stall);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            wcnt <= 0;
        end else begin
            if ((mem_rd || mem_wr) && mem_wait) wcnt <= wcnt + 1;
            else                                wcnt <= 0;
            if (mem_rd && !mem_wait) begin
                if (wmem.exists(int'(mem_addr[15:1]))) mem_rddata <= wmem[int'(mem_addr[15:1])];
                else                                   mem_rddata <= img[mem_addr[15:1]];
            end
            if (mem_wr && !mem_wait) wmem[int'(mem_addr[15:1])] = mem_wrdata;
        end
    end

    // Bus monitor
    logic        mon_en = 1'b0;
    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          both_cnt = 0;
    int          wr_cyc_cnt = 0;
    int          beef_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd && mem_wr) both_cnt++;
            if (mem_wr) wr_cyc_cnt++;
            if (mem_wr && mem_addr == 16'h0040 && mem_wrdata == 16'hBEEF) beef_cnt++;
            if (mem_rd && !mem_wait) begin
                rd_addr_q.push_back(mem_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (mem_wr && !mem_wait) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wrdata);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {5'b0, ry, rx, 1'b0, op};
    endfunction

    function automatic logic [15:0] enc_i8(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {imm, rx, 1'b1, op};
    endfunction

    function automatic logic [15:0] enc_i11(input logic [3:0] op, input logic [10:0] imm);
        return {imm, 1'b1, op};
    endfunction

    task automatic put(input logic [15:0] addr, input logic [15:0] word);
        img[addr[15:1]] = word;
    endtask

    function automatic int rd_cyc(input int i);
        return (i < rd_cyc_q.size()) ? rd_cyc_q[i] : -1000;
    endfunction

    logic [15:0] exp_rd [32] = '{
        16'h0100, 16'h0102, 16'h0104, 16'h0106, 16'h0108, 16'h0104, 16'h0106, 16'h0108,
        16'h010A, 16'h010E, 16'h0110, 16'h0112, 16'h0114, 16'h0116, 16'h0118, 16'h0050,
        16'h011A, 16'h011C, 16'h0000, 16'h011E, 16'h0122, 16'h0124, 16'h0126, 16'h0128,
        16'h012C, 16'h012E, 16'h0130, 16'h0132, 16'h0134, 16'hFFFE, 16'h0200, 16'h0202
    };
    logic [15:0] exp_wa [6] = '{16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'hFFFE};
    logic [15:0] exp_wd [6] = '{16'h0000, 16'hFFFB, 16'hBEEF, 16'h1234, 16'h122F, 16'h0000};

    initial begin
        int rel_cyc;
        int hbad;
        logic seen;

        reset      = 1'b1;
        wr_stall   = 3;
        stall_addr = 16'h0040;

        put(16'h0100, enc_r  (4'd7, 3'd0, 3'd0));     // nop
        put(16'h0102, enc_i8 (4'd0, 3'd1, 8'h05));    // mv   r1,#5
        put(16'h0104, enc_i8 (4'd2, 3'd1, 8'h05));    // sub  r1,#5
        put(16'h0106, enc_r  (4'd5, 3'd1, 3'd0));     // st   r1,[r0]
        put(16'h0108, enc_i11(4'd9, 11'h7FE));        // jz   -2
        put(16'h010A, enc_i11(4'd10, 11'h002));       // jn   +2
        put(16'h010C, 16'h000F);                      // halt
        put(16'h010E, enc_i8 (4'd0, 3'd2, 8'hEF));    // mv   r2,#EF
        put(16'h0110, enc_i8 (4'd6, 3'd2, 8'hBE));    // mvhi r2,#BE
        put(16'h0112, enc_i8 (4'd0, 3'd3, 8'h40));    // mv   r3,#40
        put(16'h0114, enc_r  (4'd5, 3'd2, 3'd3));     // st   r2,[r3]
        put(16'h0116, enc_i8 (4'd0, 3'd6, 8'h50));    // mv   r6,#50
        put(16'h0118, enc_r  (4'd4, 3'd4, 3'd6));     // ld   r4,[r6]
        put(16'h011A, enc_r  (4'd5, 3'd4, 3'd0));     // st   r4,[r0]
        put(16'h011C, enc_r  (4'd4, 3'd5, 3'd5));     // ld   r5,[r5]
        put(16'h011E, enc_i11(4'd10, 11'h002));       // jn   +2
        put(16'h0120, 16'h000F);                      // halt
        put(16'h0122, enc_r  (4'd1, 3'd5, 3'd1));     // add  r5,r1
        put(16'h0124, enc_r  (4'd5, 3'd5, 3'd0));     // st   r5,[r0]
        put(16'h0126, enc_r  (4'd3, 3'd5, 3'd5));     // cmp  r5,r5
        put(16'h0128, enc_i11(4'd9, 11'h002));        // jz   +2
        put(16'h012A, 16'h000F);                      // halt
        put(16'h012C, enc_i8 (4'd0, 3'd6, 8'hFE));    // mv   r6,#FE
        put(16'h012E, enc_i8 (4'd0, 3'd5, 8'h00));    // mv   r5,#0
        put(16'h0130, enc_i8 (4'd6, 3'd5, 8'h02));    // mvhi r5,#02
        put(16'h0132, enc_i8 (4'd0, 3'd7, 8'h33));    // mv   r7,#33
        put(16'h0134, enc_r  (4'd8, 3'd0, 3'd6));     // j    r6
        put(16'hFFFE, enc_r  (4'd12, 3'd0, 3'd5));    // call r5
        put(16'h0200, enc_r  (4'd5, 3'd7, 3'd6));     // st   r7,[r6]
        put(16'h0202, 16'h000F);                      // halt
        put(16'h0050, 16'h1234);

        repeat (3) @(negedge clk);
        check("rst_rd",     mem_rd,     1'b0);
        check("rst_wr",     mem_wr,     1'b0);
        check("rst_addr",   mem_addr,   16'h0100);
        check("rst_wrdata", mem_wrdata, 16'h0000);
        check("rst_halted", halted,     1'b0);

        mon_en  = 1'b1;
        reset   = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);
        check("first_fetch", {mem_rd, mem_addr}, {1'b1, 16'h0100});
        repeat (3) @(negedge clk);
        check("second_fetch", {mem_rd, mem_addr}, {1'b1, 16'h0102});

        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        check("halt_reached", halted, 1'b1);
        hbad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr || !halted) hbad++;
        end
        check("halt_quiet", hbad, 0);
        mon_en = 1'b0;

        check("rd_count", rd_addr_q.size(), 32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rd_addr%0d", i),
                  (i < rd_addr_q.size()) ? {16'h0, rd_addr_q[i]} : 32'hDEAD0000, {16'h0, exp_rd[i]});
        end
        check("wr_count", wr_addr_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wr%0d", i),
                  (i < wr_addr_q.size()) ? {wr_addr_q[i], wr_data_q[i]} : 32'hDEADDEAD,
                  {exp_wa[i], exp_wd[i]});
        end
        check("lat_first",  rd_cyc(0) - rel_cyc, 1);
        check("lat_alu",    rd_cyc(1) - rd_cyc(0), 3);
        check("lat_st_stall", rd_cyc(13) - rd_cyc(12), 7);
        check("lat_ld_mem", rd_cyc(15) - rd_cyc(14), 3);
        check("lat_ld",     rd_cyc(16) - rd_cyc(14), 5);
        check("st_hold",    beef_cnt, 4);
        check("wr_cycles",  wr_cyc_cnt, 9);
        check("rd_wr_both", both_cnt, 0);

        // Rerun with the store to 0x40 stalled indefinitely, then reset mid-stall.
        @(negedge clk);
        reset    = 1'b1;
        wr_stall = 1000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_wr && mem_addr == 16'h0040) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_seen", seen, 1'b1);
        repeat (2) @(negedge clk);
        check("stall_hold", {mem_wr, mem_rd, mem_addr, mem_wrdata}, {1'b1, 1'b0, 16'h0040, 16'hBEEF});
        #2 reset = 1'b1;
        #1 check("rst_mid_stall", {mem_rd, mem_wr, halted, mem_addr, mem_wrdata},
                 {1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("refetch", {mem_rd, mem_addr}, {1'b1, 16'h0100});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
